// File: rtl/vga_wport_arbiter_pkg.sv
// vga_wport_arbiter_pkg: shared VGA buffer map constants and write-port grant encodings
package vga_wport_arbiter_pkg;
  localparam logic [15:0] VGA_BUF1_START = 16'h0000;
  localparam logic [15:0] VGA_BUF2_START = 16'h1000;
  localparam logic [15:0] SCREEN_BUF_START = 16'h2000;
  localparam int FONT_COLOR_W = 8;
  typedef enum logic [1:0] {GNT_IDLE = 2'd0, GNT_REN = 2'd1, GNT_CPU = 2'd2} gnt_t;
endpackage

// File: rtl/vga_wport_arbiter_if.sv
// vga_wport_arbiter_if: renderer/CPU write requests in, RAM write port, stall, occupancy and starvation out
interface vga_wport_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH = 4
);
  logic ren_we;
  logic [ADDR_W-1:0] ren_waddr;
  logic [DATA_W-1:0] ren_wdata;
  logic cpu_we;
  logic [ADDR_W-1:0] cpu_waddr;
  logic [DATA_W-1:0] cpu_wdata;
  logic cpu_stall;
  logic mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [$clog2(DEPTH+1)-1:0] fifo_cnt;
  logic starved;
  modport slave (
    input ren_we, ren_waddr, ren_wdata, cpu_we, cpu_waddr, cpu_wdata,
    output cpu_stall, mem_we, mem_waddr, mem_wdata, fifo_cnt, starved
  );
  modport master (
    output ren_we, ren_waddr, ren_wdata, cpu_we, cpu_waddr, cpu_wdata,
    input cpu_stall, mem_we, mem_waddr, mem_wdata, fifo_cnt, starved
  );
endinterface

// File: rtl/vga_wport_arbiter_wr_fifo.sv
// vga_wr_fifo: synchronous FIFO (clk50mhz, rst, push/din, pop, head shown combinationally, cnt occupancy)
module vga_wr_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH+1)
) (
  input  logic clk50mhz,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] head,
  output logic [CW-1:0] cnt
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  assign head = mem[rptr];
  always_ff @(posedge clk50mhz)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/vga_wport_arbiter.sv
// vga_wport_arbiter: renderer-priority arbiter for the VGA RAM write port (clk50mhz, rst, bus: requests in, RAM write/stall/status out)
module vga_wport_arbiter
  import vga_wport_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 1024
) (
  input logic clk50mhz,
  input logic rst,
  vga_wport_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = $clog2(STARVE_LIMIT+1);
  gnt_t state, gnt;
  logic push, pop;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [WW-1:0] wait_cnt, wait_nxt;
  assign bus.cpu_stall = bus.fifo_cnt == CW'(DEPTH);
  assign push = bus.cpu_we & ~bus.cpu_stall;
  assign pop = gnt == GNT_CPU;
  // state holds the grant taken last cycle, so a write is presented exactly while it is non-idle
  assign bus.mem_we = state != GNT_IDLE;
  vga_wr_fifo #(.W(ADDR_W+DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk50mhz(clk50mhz),
    .rst(rst),
    .push(push),
    .din({bus.cpu_waddr, bus.cpu_wdata}),
    .pop(pop),
    .head(head),
    .cnt(bus.fifo_cnt)
  );
  always_comb begin
    gnt = bus.ren_we ? GNT_REN : (bus.fifo_cnt != '0 ? GNT_CPU : GNT_IDLE);
    wait_nxt = (gnt == GNT_REN && bus.fifo_cnt != '0)
             ? (wait_cnt == WW'(STARVE_LIMIT) ? wait_cnt : wait_cnt + 1'b1) : '0;
  end
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state <= GNT_IDLE;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
      wait_cnt <= '0;
      bus.starved <= 1'b0;
    end else begin
      state <= gnt;
      if (gnt != GNT_IDLE)
        {bus.mem_waddr, bus.mem_wdata} <= gnt == GNT_REN ? {bus.ren_waddr, bus.ren_wdata} : head;
      wait_cnt <= wait_nxt;
      bus.starved <= bus.starved | (wait_nxt == WW'(STARVE_LIMIT));
    end
  end
endmodule
